// File: rtl/keypad_controller.sv
// 4x4 keypad scanner: one-hot row drive, 2-flop column sync, press/release debounce, one event per press.
// Latency: key_valid rises DEB_CYCLES cycles after DEBOUNCE entry; no backpressure, events are fire-and-forget pulses.
module keypad_controller #(
    parameter int SCAN_DIV   = 4800,
    parameter int DEB_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols_n,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       busy
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    sync1, cs;
    logic [3:0]    rows_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic [BW-1:0] deb, deb_nxt;
    logic [3:0]    col_lat, col_nxt;
    logic          valid_nxt;
    logic [3:0]    code_nxt, new_nxt, old_nxt;
    logic [3:0]    key_dec;

    function automatic logic one_low(input logic [3:0] v);
        case (v)
            4'b0111, 4'b1011, 4'b1101, 4'b1110: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] decode(input logic [3:0] r, input logic [3:0] cpat);
        logic [1:0] ri, ci;
        case (r)
            4'b1000: ri = 2'd0;
            4'b0100: ri = 2'd1;
            4'b0010: ri = 2'd2;
            default: ri = 2'd3;
        endcase
        case (cpat)
            4'b0111: ci = 2'd0;
            4'b1011: ci = 2'd1;
            4'b1101: ci = 2'd2;
            default: ci = 2'd3;
        endcase
        case ({ri, ci})
            4'h0: decode = 4'h1;
            4'h1: decode = 4'h2;
            4'h2: decode = 4'h3;
            4'h3: decode = 4'hA;
            4'h4: decode = 4'h4;
            4'h5: decode = 4'h5;
            4'h6: decode = 4'h6;
            4'h7: decode = 4'hB;
            4'h8: decode = 4'h7;
            4'h9: decode = 4'h8;
            4'hA: decode = 4'h9;
            4'hB: decode = 4'hC;
            4'hC: decode = 4'hE;
            4'hD: decode = 4'h0;
            4'hE: decode = 4'hF;
            default: decode = 4'hD;
        endcase
    endfunction

    // rows stays frozen outside SCAN, so it doubles as the latched row
    assign key_dec = decode(rows, col_lat);
    assign busy    = (state != SCAN);

    always_comb begin
        state_nxt = state;
        rows_nxt  = rows;
        dwell_nxt = dwell;
        deb_nxt   = deb;
        col_nxt   = col_lat;
        valid_nxt = 1'b0;
        code_nxt  = key_code;
        new_nxt   = digit_new;
        old_nxt   = digit_old;
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (one_low(cs)) begin
                        col_nxt   = cs;
                        deb_nxt   = '0;
                        state_nxt = DEBOUNCE;
                    end else begin
                        rows_nxt = {rows[0], rows[3:1]};
                    end
                end else begin
                    dwell_nxt = dwell + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (cs == col_lat) begin
                    if (deb == DEB_LAST) begin
                        state_nxt = HELD;
                        valid_nxt = 1'b1;
                        code_nxt  = key_dec;
                        new_nxt   = key_dec;
                        old_nxt   = digit_new;
                    end else begin
                        deb_nxt = deb + BW'(1);
                    end
                end else begin
                    state_nxt = SCAN;
                    dwell_nxt = '0;
                end
            end
            HELD: begin
                if (cs == 4'b1111) begin
                    deb_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (cs == 4'b1111) begin
                    if (deb == DEB_LAST) begin
                        state_nxt = SCAN;
                        rows_nxt  = {rows[0], rows[3:1]};
                        dwell_nxt = '0;
                    end else begin
                        deb_nxt = deb + BW'(1);
                    end
                end else begin
                    state_nxt = HELD;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            sync1     <= 4'b1111;
            cs        <= 4'b1111;
            rows      <= 4'b1000;
            dwell     <= '0;
            deb       <= '0;
            col_lat   <= 4'b1111;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            digit_new <= 4'h0;
            digit_old <= 4'h0;
        end else begin
            state     <= state_nxt;
            sync1     <= cols_n;
            cs        <= sync1;
            rows      <= rows_nxt;
            dwell     <= dwell_nxt;
            deb       <= deb_nxt;
            col_lat   <= col_nxt;
            key_valid <= valid_nxt;
            key_code  <= code_nxt;
            digit_new <= new_nxt;
            digit_old <= old_nxt;
        end
    end

endmodule
